// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule.
// Takes the last (round-10) round key and walks the expansion backwards,
// emitting round keys 10 down to 0 over a valid/ready handshake. One key is
// produced per cycle while the consumer is ready. A done pulse follows the
// acceptance of the round-0 key.
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // FIPS-197 forward S-box, row-major (index = {row nibble, column nibble}).
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte-wise S-box substitution of a 32-bit word (MSB byte first).
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Cyclic left rotation by one byte: [b0,b1,b2,b3] -> [b1,b2,b3,b0].
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Round constant used when key r was derived from key r-1.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t       state;
    logic [127:0] key_q;
    logic [3:0]   cnt_q;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  w0_prev, w1_prev, w2_prev, w3_prev;
    logic [127:0] key_prev;

    // Undo one forward expansion step: derive key r-1 from key r = key_q.
    always_comb begin
        // NOTE: every signal gets a value on every path, so no latch is inferred.
        w0       = key_q[127:96];
        w1       = key_q[95:64];
        w2       = key_q[63:32];
        w3       = key_q[31:0];
        w3_prev  = w3 ^ w2;
        w2_prev  = w2 ^ w1;
        w1_prev  = w1 ^ w0;
        w0_prev  = w0 ^ sub_word(rot_word(w3_prev)) ^ {rcon(cnt_q), 24'h000000};
        key_prev = {w0_prev, w1_prev, w2_prev, w3_prev};
    end

    // Control FSM plus key/counter registers; all outputs come straight from flops.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state   <= IDLE;
            key_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        key_q   <= key_in;
                        cnt_q   <= 4'd10;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (key_ready) begin
                        if (cnt_q == 4'd0) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            key_q <= key_prev;
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key_valid = valid_q;
    assign round_key = key_q;
    assign round_idx = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed testbench for aes_inv_key_sched using the FIPS-197 A.1 and C.1
// AES-128 key expansions as reference round-key tables.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic         key_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int checks = 0;
    int passed = 0;

    // FIPS-197 A.1 round keys, index = round number.
    localparam logic [127:0] A1_KEYS [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    // FIPS-197 C.1 round keys, index = round number.
    localparam logic [127:0] C1_KEYS [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
        step();
        step();
        checks++;
        if ({key_valid, busy, done, round_idx, round_key} !== 135'd0)
            $display("FAIL reset_state: got kv=%b busy=%b done=%b idx=%0d key=%h, want all zero",
                     key_valid, busy, done, round_idx, round_key);
        else passed++;
        rst = 1'b0;
        step();
    endtask

    // A.1 vector at full throughput, then the done pulse and its single-cycle width.
    task automatic test_fips_a1();
        key_in = A1_KEYS[10]; start = 1'b1; key_ready = 1'b1;
        step();
        start = 1'b0; key_in = 128'hdeadbeef_00000000_cafef00d_12345678;
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if ({key_valid, busy, done, round_idx, round_key} !== {1'b1, 1'b1, 1'b0, 4'(r), A1_KEYS[r]})
                $display("FAIL a1_round%0d: got kv=%b busy=%b done=%b idx=%0d key=%h, want idx=%0d key=%h",
                         r, key_valid, busy, done, round_idx, round_key, r, A1_KEYS[r]);
            else passed++;
            step();
        end
        checks++;
        if ({key_valid, busy, done} !== 3'b001)
            $display("FAIL a1_done_pulse: got kv=%b busy=%b done=%b, want 0 0 1", key_valid, busy, done);
        else passed++;
        step();
        checks++;
        if ({key_valid, busy, done} !== 3'b000)
            $display("FAIL a1_done_width: got kv=%b busy=%b done=%b, want 0 0 0", key_valid, busy, done);
        else passed++;
        key_ready = 1'b0;
    endtask

    // C.1 vector with a 5-cycle stall at round 7; outputs must hold and no key is lost.
    task automatic test_backpressure_c1();
        int emitted = 0;
        key_in = C1_KEYS[10]; start = 1'b1; key_ready = 1'b1;
        step();
        start = 1'b0; key_in = '1;
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if ({key_valid, round_idx, round_key} !== {1'b1, 4'(r), C1_KEYS[r]})
                $display("FAIL c1_round%0d: got kv=%b idx=%0d key=%h, want idx=%0d key=%h",
                         r, key_valid, round_idx, round_key, r, C1_KEYS[r]);
            else passed++;
            if (r == 7) begin
                key_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    checks++;
                    if ({key_valid, busy, round_idx, round_key} !== {1'b1, 1'b1, 4'd7, C1_KEYS[7]})
                        $display("FAIL c1_stall%0d: got kv=%b busy=%b idx=%0d key=%h, want idx=7 key=%h",
                                 s, key_valid, busy, round_idx, round_key, C1_KEYS[7]);
                    else passed++;
                end
                key_ready = 1'b1;
            end
            if (key_valid && key_ready) emitted++;
            step();
        end
        checks++;
        if (emitted !== 11)
            $display("FAIL c1_emitted_count: got %0d, want 11", emitted);
        else passed++;
        checks++;
        if ({key_valid, done} !== 2'b01)
            $display("FAIL c1_done_pulse: got kv=%b done=%b, want 0 1", key_valid, done);
        else passed++;
        key_ready = 1'b0;
        step();
    endtask

    // start and key_in toggled throughout EMIT must not disturb the A.1 sequence.
    task automatic test_start_during_emit();
        key_in = A1_KEYS[10]; start = 1'b1; key_ready = 1'b1;
        step();
        for (int r = 10; r >= 0; r--) begin
            start  = (r != 0);
            key_in = {$urandom, $urandom, $urandom, $urandom};
            checks++;
            if ({key_valid, round_idx, round_key} !== {1'b1, 4'(r), A1_KEYS[r]})
                $display("FAIL poke_round%0d: got kv=%b idx=%0d key=%h, want idx=%0d key=%h",
                         r, key_valid, round_idx, round_key, r, A1_KEYS[r]);
            else passed++;
            step();
        end
        start = 1'b0;
        checks++;
        if ({key_valid, busy, done} !== 3'b001)
            $display("FAIL poke_done_pulse: got kv=%b busy=%b done=%b, want 0 0 1", key_valid, busy, done);
        else passed++;
        key_ready = 1'b0;
        step();
    endtask

    // Reset at round 4 wins over start/key_ready, gives no done, then a clean restart.
    task automatic test_reset_mid();
        key_in = C1_KEYS[10]; start = 1'b1; key_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r > 4; r--) step();
        checks++;
        if ({key_valid, round_idx, round_key} !== {1'b1, 4'd4, C1_KEYS[4]})
            $display("FAIL rstmid_at_idx4: got kv=%b idx=%0d key=%h, want idx=4 key=%h",
                     key_valid, round_idx, round_key, C1_KEYS[4]);
        else passed++;
        rst = 1'b1; start = 1'b1; key_in = A1_KEYS[10];
        step();
        checks++;
        if ({key_valid, busy, done, round_idx, round_key} !== 135'd0)
            $display("FAIL rstmid_outputs: got kv=%b busy=%b done=%b idx=%0d key=%h, want all zero",
                     key_valid, busy, done, round_idx, round_key);
        else passed++;
        rst = 1'b0; start = 1'b0;
        step();
        checks++;
        if ({key_valid, busy, done} !== 3'b000)
            $display("FAIL rstmid_no_done: got kv=%b busy=%b done=%b, want 0 0 0", key_valid, busy, done);
        else passed++;
        start = 1'b1; key_in = A1_KEYS[10];
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if ({key_valid, round_idx, round_key} !== {1'b1, 4'(r), A1_KEYS[r]})
                $display("FAIL restart_round%0d: got kv=%b idx=%0d key=%h, want idx=%0d key=%h",
                         r, key_valid, round_idx, round_key, r, A1_KEYS[r]);
            else passed++;
            step();
        end
        checks++;
        if (done !== 1'b1)
            $display("FAIL restart_done: got done=%b, want 1", done);
        else passed++;
        key_ready = 1'b0;
        step();
    endtask

    // start raised during the done cycle launches the next sequence immediately.
    task automatic test_back_to_back();
        key_in = A1_KEYS[10]; start = 1'b1; key_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) step();
        checks++;
        if ({key_valid, done} !== 2'b01)
            $display("FAIL b2b_done_cycle: got kv=%b done=%b, want 0 1", key_valid, done);
        else passed++;
        start = 1'b1; key_in = C1_KEYS[10];
        step();
        start = 1'b0; key_in = '0;
        checks++;
        if ({key_valid, busy, done, round_idx, round_key} !== {1'b1, 1'b1, 1'b0, 4'd10, C1_KEYS[10]})
            $display("FAIL b2b_first_key: got kv=%b busy=%b done=%b idx=%0d key=%h, want 1 1 0 idx=10 key=%h",
                     key_valid, busy, done, round_idx, round_key, C1_KEYS[10]);
        else passed++;
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if ({key_valid, round_idx, round_key} !== {1'b1, 4'(r), C1_KEYS[r]})
                $display("FAIL b2b_round%0d: got kv=%b idx=%0d key=%h, want idx=%0d key=%h",
                         r, key_valid, round_idx, round_key, r, C1_KEYS[r]);
            else passed++;
            step();
        end
        checks++;
        if ({key_valid, done} !== 2'b01)
            $display("FAIL b2b_second_done: got kv=%b done=%b, want 0 1", key_valid, done);
        else passed++;
        key_ready = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_ready = 1'b0; key_in = '0;
        test_reset();
        test_fips_a1();
        test_backpressure_c1();
        test_start_during_emit();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
